// File: rtl/qdense_seq.sv
// qdense_seq: time-multiplexed quantized dense layer with a fused quantizing
// activation (ReLU + unsigned saturation, or signed saturation).
//
// Each cycle of the MAC phase multiplies P input elements by P kernel
// elements of the current neuron and accumulates them. One neuron takes
// N = XD/P cycles and the whole vector takes YD*N cycles. The bias is added
// on the last chunk, and the activated value is written into that neuron's
// output slot.
//
// Ports:
//   clk      in   clock
//   rstn     in   asynchronous active-low reset
//   copy     in   shift-enable for the serial weight chain (ignored while busy)
//   k        in   serial weight bit, enters at the chain MSB
//   busy     out  high whenever the block is not IDLE
//   s_valid  in   input vector valid
//   s_ready  out  input accept (high only in IDLE)
//   s_x      in   [XD-1:0][XB-1:0] signed input vector
//   m_valid  out  result valid (DONE state)
//   m_ready  in   result accept
//   m_y      out  [YD-1:0][YB-1:0] activated results
module qdense_seq #(
    parameter int XD    = 512,
    parameter int YD    = 16,
    parameter int XB    = 12,
    parameter int KB    = 7,
    parameter int P     = 8,
    parameter int SHIFT = 4,
    parameter int YB    = 14,
    parameter int RELU  = 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    copy,
    input  logic                    k,
    output logic                    busy,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [XD-1:0][XB-1:0]   s_x,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [YD-1:0][YB-1:0]   m_y
);

    localparam int N  = XD / P;
    localparam int AB = XB + KB + $clog2(XD + 1);
    localparam int VW = AB + 1;                       // bias-add width
    localparam int WB = (XD * YD + YD) * KB;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int JW = (YD > 1) ? $clog2(YD) : 1;
    // Activation work width: holds the pre-activation value and both clamp
    // limits as signed numbers without overflow.
    localparam int EW = ((VW > YB + 1) ? VW : YB + 1) + 1;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [WB-1:0]           r_w;
    logic [XD-1:0][XB-1:0]   r_x;
    logic signed [AB-1:0]    r_acc;
    logic [CW-1:0]           r_c;
    logic [JW-1:0]           r_j;
    logic [YD-1:0][YB-1:0]   r_y;

    logic signed [AB-1:0]    w_psum;
    logic signed [AB-1:0]    w_acc_in;
    logic signed [KB-1:0]    w_bias;
    logic signed [VW-1:0]    w_pre;
    logic                    w_last_chunk;
    logic                    w_last_neuron;

    // Quantizing activation: optional ReLU, floor shift, then clamp to the
    // output range (unsigned for ReLU, two's complement otherwise).
    function automatic logic [YB-1:0] act(input logic signed [VW-1:0] v);
        logic signed [EW-1:0] r;
        logic signed [EW-1:0] hi;
        logic signed [EW-1:0] lo;
        r = EW'(v);
        if (RELU != 0 && r < 0) r = '0;
        r = r >>> SHIFT;
        if (RELU != 0) begin
            hi = EW'({YB{1'b1}});
            lo = '0;
        end else begin
            hi = EW'({(YB-1){1'b1}});
            lo = ~hi;
        end
        if (r > hi)      r = hi;
        else if (r < lo) r = lo;
        return r[YB-1:0];
    endfunction

    // Partial sum of the current chunk: P signed products, kernel (i,j)
    // lives at flat chain element j*XD+i.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned (which would infer a latch); blocking '=' is
        // correct here because the loop accumulates combinationally.
        w_psum = '0;
        for (int p = 0; p < P; p++) begin
            w_psum = w_psum
                   + AB'($signed(r_x[int'(r_c) * P + p]))
                   * AB'($signed(r_w[(int'(r_j) * XD + int'(r_c) * P + p) * KB +: KB]));
        end
    end

    assign w_last_chunk  = (r_c == CW'(N - 1));
    assign w_last_neuron = (r_j == JW'(YD - 1));
    assign w_acc_in      = (r_c == '0) ? w_psum : r_acc + w_psum;
    assign w_bias        = r_w[(XD * YD + int'(r_j)) * KB +: KB];
    assign w_pre         = VW'(w_acc_in) + VW'(w_bias);

    assign s_ready = (r_state == IDLE);
    assign busy    = (r_state != IDLE);
    assign m_valid = (r_state == DONE);
    assign m_y     = r_y;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (s_valid) w_next = MAC;
            MAC:     if (w_last_chunk && w_last_neuron) w_next = DONE;
            DONE:    if (m_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: the weight chain is deliberately cleared on reset so a
            // reset always forces a reload; most wide storage would be left
            // unreset.
            r_w   <= '0;
            r_x   <= '0;
            r_acc <= '0;
            r_c   <= '0;
            r_j   <= '0;
            r_y   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking '<=' so every register
            // here sees the pre-edge values of the others.
            if (copy && r_state == IDLE) r_w <= {k, r_w[WB-1:1]};
            case (r_state)
                IDLE: begin
                    if (s_valid) begin
                        r_x <= s_x;
                        r_c <= '0;
                        r_j <= '0;
                    end
                end
                MAC: begin
                    r_acc <= w_acc_in;
                    if (w_last_chunk) begin
                        r_y[r_j] <= act(w_pre);
                        r_c      <= '0;
                        r_j      <= r_j + 1'b1;
                    end else begin
                        r_c <= r_c + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_qdense_seq.sv
// Testbench for qdense_seq. Two instances share all inputs: one with the
// ReLU activation, one with signed saturation. A reference model computes
// each neuron as a plain dot product over the weight chain image; expected
// results go into per-instance queues and a monitor compares them at the
// output handshake and checks the m_valid latency.
module tb_qdense_seq;

    localparam int XD = 4, YD = 2, XB = 4, KB = 4, P = 2, SHIFT = 1, YB = 4;
    localparam int N   = XD / P;
    localparam int WB  = (XD * YD + YD) * KB;
    localparam int LAT = YD * N + 1;

    typedef logic [XD-1:0][XB-1:0] xvec_t;
    typedef logic [YD-1:0][YB-1:0] yvec_t;
    typedef struct {
        yvec_t y;
        int    t;
    } exp_t;

    logic    clk;
    logic    rstn;
    logic    copy;
    logic    k;
    logic    s_valid;
    xvec_t   s_x;
    logic    m_ready;
    logic    busy_o    [2];
    logic    s_ready_o [2];
    logic    m_valid_o [2];
    yvec_t   m_y_o     [2];

    int            n_pass = 0;
    int            n_tot  = 0;
    int            cyc    = 0;
    logic [WB-1:0] tb_chain;
    exp_t          sb [2][$];
    logic          mv_prev [2];
    exp_t          mon_e;

    qdense_seq #(.XD(XD), .YD(YD), .XB(XB), .KB(KB), .P(P), .SHIFT(SHIFT),
                 .YB(YB), .RELU(1)) u_relu (
        .clk(clk), .rstn(rstn), .copy(copy), .k(k), .busy(busy_o[0]),
        .s_valid(s_valid), .s_ready(s_ready_o[0]), .s_x(s_x),
        .m_valid(m_valid_o[0]), .m_ready(m_ready), .m_y(m_y_o[0])
    );

    qdense_seq #(.XD(XD), .YD(YD), .XB(XB), .KB(KB), .P(P), .SHIFT(SHIFT),
                 .YB(YB), .RELU(0)) u_sat (
        .clk(clk), .rstn(rstn), .copy(copy), .k(k), .busy(busy_o[1]),
        .s_valid(s_valid), .s_ready(s_ready_o[1]), .s_x(s_x),
        .m_valid(m_valid_o[1]), .m_ready(m_ready), .m_y(m_y_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: y[j] = act(sum_i x[i]*k(i,j) + b[j]) with whole-integer math.
    function automatic yvec_t model(input logic [WB-1:0] ch, input xvec_t x, input bit relu);
        yvec_t                y;
        longint               acc, hi, lo;
        logic signed [KB-1:0] kv;
        logic signed [XB-1:0] xv;
        for (int j = 0; j < YD; j++) begin
            acc = 0;
            for (int i = 0; i < XD; i++) begin
                kv  = ch[(j * XD + i) * KB +: KB];
                xv  = x[i];
                acc = acc + longint'(xv) * longint'(kv);
            end
            kv  = ch[(XD * YD + j) * KB +: KB];
            acc = acc + longint'(kv);
            if (relu && acc < 0) acc = 0;
            acc = acc >>> SHIFT;
            if (relu) begin
                hi = (longint'(1) << YB) - 1;
                lo = 0;
            end else begin
                hi = (longint'(1) << (YB - 1)) - 1;
                lo = -hi - 1;
            end
            if (acc > hi)      acc = hi;
            else if (acc < lo) acc = lo;
            y[j] = acc[YB-1:0];
        end
        return y;
    endfunction

    function automatic logic [WB-1:0] mk_uniform(input int kv, input int b0, input int b1);
        logic [WB-1:0]  v;
        logic [31:0]    t;
        v = '0;
        for (int e = 0; e < XD * YD; e++) begin
            t = kv;
            v[e * KB +: KB] = t[KB-1:0];
        end
        t = b0;
        v[(XD * YD) * KB +: KB] = t[KB-1:0];
        t = b1;
        v[(XD * YD + 1) * KB +: KB] = t[KB-1:0];
        return v;
    endfunction

    // Shift nb bits of v (LSB first) into the chain; only called while idle.
    task automatic shift_in(input logic [WB-1:0] v, input int nb);
        for (int b = 0; b < nb; b++) begin
            @(posedge clk); #1;
            copy     = 1'b1;
            k        = v[b];
            tb_chain = {v[b], tb_chain[WB-1:1]};
        end
        @(posedge clk); #1;
        copy = 1'b0;
    endtask

    task automatic send(input xvec_t x);
        exp_t e0, e1;
        bit   ok;
        ok = 1'b0;
        @(posedge clk); #1;
        s_valid = 1'b1;
        s_x     = x;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (s_ready_o[0]) begin
                e0.y = model(tb_chain, x, 1'b1);
                e0.t = cyc;
                e1.y = model(tb_chain, x, 1'b0);
                e1.t = cyc;
                sb[0].push_back(e0);
                sb[1].push_back(e1);
                ok = 1'b1;
                break;
            end
        end
        check("accepted", ok, 1);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit rnd);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            if (rnd) m_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (sb[0].size() == 0 && sb[1].size() == 0 && !busy_o[0] && !busy_o[1]) begin
                done = 1'b1;
                break;
            end
        end
        m_ready = 1'b1;
        check("drain", done, 1);
    endtask

    // Monitor: latency on the rising edge of m_valid, data on the handshake.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rstn && m_valid_o[d] && !mv_prev[d]) begin
                check($sformatf("out_expected%0d", d), sb[d].size() != 0, 1);
                if (sb[d].size() != 0)
                    check($sformatf("latency%0d", d), cyc, sb[d][0].t + LAT);
            end
            if (rstn && m_valid_o[d] && m_ready && sb[d].size() != 0) begin
                mon_e = sb[d].pop_front();
                check($sformatf("m_y%0d", d), m_y_o[d], mon_e.y);
            end
            mv_prev[d] = m_valid_o[d];
        end
    end

    initial begin
        xvec_t         xb;
        xvec_t         xr;
        yvec_t         yexp [2];
        logic [31:0]   r32;
        logic [63:0]   r64;
        bit            seen;

        xb       = 16'h4321;
        rstn     = 1'b0;
        copy     = 1'b0;
        k        = 1'b0;
        s_valid  = 1'b0;
        s_x      = '0;
        m_ready  = 1'b1;
        tb_chain = '0;
        mv_prev[0] = 1'b0;
        mv_prev[1] = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_m_valid", m_valid_o[d], 0);
            check("rst_m_y",     m_y_o[d],     0);
            check("rst_s_ready", s_ready_o[d], 1);
            check("rst_busy",    busy_o[d],    0);
        end
        @(posedge clk); #1;
        rstn = 1'b1;

        // Basic: kernels 1, biases 0 -> 10>>1 = 5 per neuron
        shift_in(mk_uniform(1, 0, 0), WB);
        send(xb);
        @(negedge clk);
        check("busy_after_accept", busy_o[0], 1);
        wait_idle(1'b0);

        // ReLU + bias, then saturation in both activation modes
        shift_in(mk_uniform(-1, 0, 7), WB);
        send(xb);
        wait_idle(1'b0);
        shift_in(mk_uniform(7, 0, 0), WB);
        send(16'h7777);
        wait_idle(1'b0);
        shift_in(mk_uniform(-8, 0, 0), WB);
        send(16'h7777);
        wait_idle(1'b0);

        // Backpressure: result held 10 cycles, stray s_valid pulse ignored
        shift_in(mk_uniform(1, 0, 0), WB);
        m_ready = 1'b0;
        yexp[0] = model(tb_chain, xb, 1'b1);
        yexp[1] = model(tb_chain, xb, 1'b0);
        send(xb);
        seen = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (m_valid_o[0]) begin
                seen = 1'b1;
                break;
            end
        end
        check("bp_valid_seen", seen, 1);
        for (int i = 0; i < 10; i++) begin
            for (int d = 0; d < 2; d++) begin
                check("bp_m_valid", m_valid_o[d], 1);
                check("bp_m_y",     m_y_o[d],     yexp[d]);
                check("bp_s_ready", s_ready_o[d], 0);
            end
            @(posedge clk); #1;
            s_valid = (i == 3);
            s_x     = 16'h1111;
            @(negedge clk);
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rel_m_valid", m_valid_o[0], 0);
        check("rel_s_ready", s_ready_o[0], 1);
        repeat (4) @(negedge clk);
        check("no_stray_accept", busy_o[0], 0);

        // Load lockout: copy toggled during compute must not disturb weights
        shift_in(mk_uniform(1, 0, 0), WB);
        send(xb);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            copy = 1'b1;
            k    = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        copy = 1'b0;
        wait_idle(1'b0);
        // One extra bit in IDLE moves the whole chain by exactly one position
        shift_in('0, 1);
        send(xb);
        wait_idle(1'b0);

        // Randomized weights, inputs and output backpressure
        for (int it = 0; it < 8; it++) begin
            r64 = {$urandom, $urandom};
            shift_in(r64[WB-1:0], WB);
            r32 = $urandom;
            xr  = r32[XD*XB-1:0];
            send(xr);
            wait_idle(1'b1);
        end

        // Reset in the 2nd MAC cycle
        shift_in(mk_uniform(1, 0, 0), WB);
        send(xb);
        @(posedge clk); #1;
        rstn = 1'b0;
        sb[0].delete();
        sb[1].delete();
        tb_chain = '0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("mid_rst_m_valid", m_valid_o[d], 0);
            check("mid_rst_m_y",     m_y_o[d],     0);
            check("mid_rst_s_ready", s_ready_o[d], 1);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        // Weights were cleared by reset: without a reload the result is zero
        send(xb);
        wait_idle(1'b0);
        shift_in(mk_uniform(1, 0, 0), WB);
        send(xb);
        wait_idle(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
